// File: rtl/sr_pulse_ctrl_pkg.sv
// Shared types and helpers for the SR pulse controller: FSM states, slot
// contents and the counter-width helper used by the top and the debouncer.
package sr_pulse_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_SET  = 2'd1,
        SLOT_RST  = 2'd2
    } slot_t;

    // Width of a counter that must hold 0 .. max_count-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/sr_pulse_ctrl_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge detector for one
// raw push-button; rise is a single-cycle request per accepted press.
module sr_pulse_ctrl_debounce
    import sr_pulse_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // The stable level only flips after DEBOUNCE_CYCLES consecutive differing
    // samples; rise is raised on the same edge so the top can issue a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
                rise   <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Command stage for the gate-level SR flip-flop: debounced button requests are
// turned into fixed-width, mutually exclusive S/R pulses with a holdoff gap.
module sr_pulse_ctrl
    import sr_pulse_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic q_exp
);

    localparam int            MAXC        = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int            CW          = cnt_width(MAXC);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam state_t        AFTER_PULSE = (HOLDOFF_CYCLES > 0) ? HOLDOFF : IDLE;

    logic          set_req;
    logic          rst_req;
    state_t        state;
    state_t        state_nxt;
    slot_t         slot;
    slot_t         slot_eff;
    slot_t         kind;
    logic [CW-1:0] cnt;
    logic          cnt_done;

    sr_pulse_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (set_btn),
        .rise (set_req)
    );

    sr_pulse_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (rst_btn),
        .rise (rst_req)
    );

    // Slot as seen this cycle: newest request wins, a collision empties it.
    // IDLE looks at this directly so a fresh request issues without an extra cycle.
    always_comb begin
        slot_eff = slot;
        if (set_req && rst_req) begin
            slot_eff = SLOT_NONE;
        end else if (set_req) begin
            slot_eff = SLOT_SET;
        end else if (rst_req) begin
            slot_eff = SLOT_RST;
        end
    end

    always_comb begin
        cnt_done = (state == PULSE) ? (cnt == PULSE_LAST) : (cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (slot_eff != SLOT_NONE) state_nxt = PULSE;
            PULSE:   if (cnt_done) state_nxt = AFTER_PULSE;
            HOLDOFF: if (cnt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot, latched pulse type, phase counter, conflict flag and expected Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= SLOT_NONE;
            kind     <= SLOT_NONE;
            cnt      <= '0;
            conflict <= 1'b0;
            q_exp    <= 1'b0;
        end else begin
            conflict <= set_req & rst_req;
            slot     <= slot_eff;
            if (state != state_nxt) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE && slot_eff != SLOT_NONE) begin
                slot  <= SLOT_NONE;
                kind  <= slot_eff;
                q_exp <= (slot_eff == SLOT_SET);
            end
        end
    end

    always_comb begin
        S    = (state == PULSE) && (kind == SLOT_SET);
        R    = (state == PULSE) && (kind == SLOT_RST);
        busy = (state != IDLE);
    end

endmodule
